// File: rtl/mmc1_pkg.sv
// Shared constants for the MMC1 serial-load port: register indices,
// control-register reset value, field positions and counter states.
package mmc1_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CHR0 = 2'd1;
    localparam logic [1:0] REG_CHR1 = 2'd2;
    localparam logic [1:0] REG_PRG  = 2'd3;

    // OR-ed into ctrl on a bit-7 reset: PRG mode 3 (fix last bank at $C000)
    localparam logic [4:0] CTRL_RST = 5'b01100;

    // ctrl fields
    localparam int CTRL_MIR_LSB      = 0;
    localparam int CTRL_MIR_MSB      = 1;
    localparam int CTRL_PRG_MODE_LSB = 2;
    localparam int CTRL_PRG_MODE_MSB = 3;
    localparam int CTRL_CHR_MODE_BIT = 4;

    // prg fields
    localparam int PRG_BANK_LSB     = 0;
    localparam int PRG_BANK_MSB     = 3;
    localparam int PRG_WRAM_DIS_BIT = 4;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FILL  = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/mmc1_shift5.sv
// LSB-first serial shifter with bit counter. Produces a combinational
// commit strobe and word on the fifth accepted bit, and a reset strobe
// when a bit-7 write is seen.
module mmc1_shift5
    import mmc1_pkg::*;
#(
    parameter int NBITS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_cyc,
    input  logic             g,
    input  logic             d0,
    input  logic             d7,
    output logic [2:0]       bit_cnt,
    output logic             commit,
    output logic [NBITS-1:0] word,
    output logic             rst_take
);

    cnt_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [NBITS-1:0] shift_q, shift_d;

    // Counter/shifter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            cnt_q   <= 3'd0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next state: bit-7 reset beats everything, RMW second writes are ignored
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        commit   = 1'b0;
        rst_take = 1'b0;
        word     = {d0, shift_q[NBITS-1:1]};
        if (wr_cyc && d7) begin
            rst_take = 1'b1;
            shift_d  = '0;
            cnt_d    = 3'd0;
            state_d  = S_EMPTY;
        end else if (wr_cyc && !g) begin
            if (cnt_q == 3'(NBITS - 1)) begin
                commit  = 1'b1;
                shift_d = '0;
                cnt_d   = 3'd0;
                state_d = S_EMPTY;
            end else begin
                shift_d = word;
                cnt_d   = cnt_q + 3'd1;
                state_d = S_FILL;
            end
        end
    end

    assign bit_cnt = cnt_q;

endmodule

// File: rtl/mmc1_serial_ctrl.sv
// MMC1 serial-load port: RMW write guard, address decode and the four
// 5-bit configuration registers fed by the serial shifter.
module mmc1_serial_ctrl
    import mmc1_pkg::*;
#(
    parameter int         NBITS    = 5,
    parameter logic [4:0] CTRL_RST = mmc1_pkg::CTRL_RST
) (
    input  logic       m2,
    input  logic       nres,
    input  logic       romsel_n,
    input  logic       cpu_rw,
    input  logic [1:0] cpu_a,
    input  logic       cpu_d0,
    input  logic       cpu_d7,
    output logic [4:0] ctrl,
    output logic [4:0] chr0,
    output logic [4:0] chr1,
    output logic [4:0] prg,
    output logic [3:0] reg_we,
    output logic       sr_rst,
    output logic [2:0] bit_cnt
);

    logic             wr_cyc;
    logic             g_q, g_d;
    logic [NBITS-1:0] ctrl_q, ctrl_d, chr0_q, chr0_d, chr1_q, chr1_d, prg_q, prg_d;
    logic [3:0]       reg_we_q, reg_we_d;
    logic             sr_rst_q, sr_rst_d;
    logic             commit, rst_take;
    logic [NBITS-1:0] word;

    assign wr_cyc = !romsel_n && !cpu_rw;

    mmc1_shift5 #(.NBITS(NBITS)) u_shift (
        .clk      (m2),
        .rst_n    (nres),
        .wr_cyc   (wr_cyc),
        .g        (g_q),
        .d0       (cpu_d0),
        .d7       (cpu_d7),
        .bit_cnt  (bit_cnt),
        .commit   (commit),
        .word     (word),
        .rst_take (rst_take)
    );

    // Guard, strobes and register file
    always_ff @(posedge m2 or negedge nres) begin
        if (!nres) begin
            g_q      <= 1'b0;
            ctrl_q   <= CTRL_RST;
            chr0_q   <= '0;
            chr1_q   <= '0;
            prg_q    <= '0;
            reg_we_q <= 4'b0;
            sr_rst_q <= 1'b0;
        end else begin
            g_q      <= g_d;
            ctrl_q   <= ctrl_d;
            chr0_q   <= chr0_d;
            chr1_q   <= chr1_d;
            prg_q    <= prg_d;
            reg_we_q <= reg_we_d;
            sr_rst_q <= sr_rst_d;
        end
    end

    // Commit decode: cpu_a of the fifth write alone picks the target
    always_comb begin
        g_d      = wr_cyc;
        ctrl_d   = ctrl_q;
        chr0_d   = chr0_q;
        chr1_d   = chr1_q;
        prg_d    = prg_q;
        reg_we_d = 4'b0;
        sr_rst_d = rst_take;
        if (rst_take) begin
            ctrl_d = ctrl_q | CTRL_RST;
        end else if (commit) begin
            reg_we_d = 4'b0001 << cpu_a;
            case (cpu_a)
                REG_CTRL: ctrl_d = word;
                REG_CHR0: chr0_d = word;
                REG_CHR1: chr1_d = word;
                REG_PRG:  prg_d  = word;
                default:  ;
            endcase
        end
    end

    assign ctrl   = ctrl_q;
    assign chr0   = chr0_q;
    assign chr1   = chr1_q;
    assign prg    = prg_q;
    assign reg_we = reg_we_q;
    assign sr_rst = sr_rst_q;

endmodule
